// File: rtl/burst_write_splitter.sv
// burst_write_splitter
// Splits long write requests (start address + beat count) into sub-bursts of
// at most MAX_BURST_LENGTH beats and re-emits the data stream with a last flag
// at every sub-burst end. A small FIFO of sub-burst lengths links the address
// side to the data side, so data is only passed once its sub-burst is issued.
// Optional feature macro: BURST_WRITE_SPLITTER_4K_EN (keeps every sub-burst
// inside one 4 KB page).

module burst_write_splitter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_BURST_LENGTH = 4,
    parameter int ADDR_STEP        = 1,
    parameter int LEN_FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [7:0]            s_length,
    input  logic                  s_addr_valid,
    output logic                  s_addr_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_data_valid,
    output logic                  s_data_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [7:0]            m_length,
    output logic                  m_addr_valid,
    input  logic                  m_addr_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_data_last,
    output logic                  m_data_valid,
    input  logic                  m_data_ready
);

    localparam int         STEP_SHIFT = $clog2(ADDR_STEP);
    localparam int         PTR_W      = $clog2(LEN_FIFO_DEPTH);
    localparam logic [8:0] MAX_LEN    = 9'(MAX_BURST_LENGTH);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [8:0]            remaining_q, remaining_d;
    logic [8:0]            chunk;
    logic [8:0]            chunk_m1;

    logic [7:0]            fifo_mem_q [LEN_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  fifo_full, fifo_nonempty;
    logic                  push, pop;

    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_data_valid_q, m_data_last_q;
    logic [7:0]            beat_cnt_q;
    logic                  data_accept, last_beat;

    assign fifo_full     = (count_q == (PTR_W+1)'(LEN_FIFO_DEPTH));
    assign fifo_nonempty = (count_q != '0);

    assign s_addr_ready  = (state_q == IDLE) && rst_n;
    assign m_addr_valid  = (state_q == SPLIT) && !fifo_full;
    assign chunk_m1      = chunk - 9'd1;
    assign m_addr        = (state_q == SPLIT) ? cur_addr_q : '0;
    assign m_length      = (state_q == SPLIT) ? chunk_m1[7:0] : 8'd0;

    assign push          = m_addr_valid && m_addr_ready;
    assign s_data_ready  = fifo_nonempty && (!m_data_valid_q || m_data_ready);
    assign data_accept   = s_data_valid && s_data_ready;
    assign last_beat     = (beat_cnt_q == fifo_mem_q[rd_ptr_q]);
    assign pop           = data_accept && last_beat;

    assign m_data        = m_data_q;
    assign m_data_valid  = m_data_valid_q;
    assign m_data_last   = m_data_last_q;

    // Size of the next sub-burst: what is left, capped by the burst limit
    // and, when enabled, by the room left in the current 4 KB page.
`ifdef BURST_WRITE_SPLITTER_4K_EN
    logic [12:0] page_room;
    always_comb begin
        chunk     = (remaining_q < MAX_LEN) ? remaining_q : MAX_LEN;
        page_room = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> STEP_SHIFT;
        if ({4'b0, chunk} > page_room) begin
            chunk = page_room[8:0];
        end
    end
`else
    always_comb begin
        chunk = (remaining_q < MAX_LEN) ? remaining_q : MAX_LEN;
    end
`endif

    // Address FSM next state: latch a request in IDLE, walk through it in SPLIT.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (s_addr_valid && s_addr_ready) begin
                    cur_addr_d  = s_addr;
                    remaining_d = {1'b0, s_length} + 9'd1;
                    state_d     = SPLIT;
                end
            end
            SPLIT: begin
                if (push) begin
                    cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(chunk) << STEP_SHIFT);
                    remaining_d = remaining_q - chunk;
                    if (remaining_q == chunk) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address FSM registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    // Length FIFO storage; contents are only meaningful while occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= chunk_m1[7:0];
        end
    end

    // Length FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // One-entry data output register with beat counting per sub-burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data_q       <= '0;
            m_data_valid_q <= 1'b0;
            m_data_last_q  <= 1'b0;
            beat_cnt_q     <= '0;
        end else if (data_accept) begin
            m_data_q       <= s_data;
            m_data_valid_q <= 1'b1;
            m_data_last_q  <= last_beat;
            beat_cnt_q     <= last_beat ? 8'd0 : beat_cnt_q + 8'd1;
        end else if (m_data_ready) begin
            m_data_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_burst_write_splitter.sv
// Directed self-checking bench for burst_write_splitter (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked there
// or after a further settle delay, well away from the next edge.

module tb_burst_write_splitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_addr;
    logic [7:0]  s_length;
    logic        s_addr_valid;
    logic        s_addr_ready;
    logic [31:0] s_data;
    logic        s_data_valid;
    logic        s_data_ready;
    logic [31:0] m_addr;
    logic [7:0]  m_length;
    logic        m_addr_valid;
    logic        m_addr_ready;
    logic [31:0] m_data;
    logic        m_data_last;
    logic        m_data_valid;
    logic        m_data_ready;

    int checkCount = 0;
    int passCount  = 0;

    burst_write_splitter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_BURST_LENGTH(4),
        .ADDR_STEP(1),
        .LEN_FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_addr(s_addr),
        .s_length(s_length),
        .s_addr_valid(s_addr_valid),
        .s_addr_ready(s_addr_ready),
        .s_data(s_data),
        .s_data_valid(s_data_valid),
        .s_data_ready(s_data_ready),
        .m_addr(m_addr),
        .m_length(m_length),
        .m_addr_valid(m_addr_valid),
        .m_addr_ready(m_addr_ready),
        .m_data(m_data),
        .m_data_last(m_data_last),
        .m_data_valid(m_data_valid),
        .m_data_ready(m_data_ready)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic dataValid, input logic [31:0] dataBeat);
        s_data_valid = dataValid;
        s_data       = dataBeat;
    endtask

    task automatic applyRequest(input logic [31:0] addr, input logic [7:0] len);
        s_addr       = addr;
        s_length     = len;
        s_addr_valid = 1'b1;
        #1;
        checkOutput("req_ready", s_addr_ready, 1);
        tick();
        s_addr_valid = 1'b0;
        #1;
    endtask

    task automatic checkSubBurst(input string tag, input logic [31:0] addr, input logic [7:0] len);
        checkOutput({tag, "_valid"}, m_addr_valid, 1);
        checkOutput({tag, "_addr"}, m_addr, 64'(addr));
        checkOutput({tag, "_len"}, m_length, 64'(len));
    endtask

    // Streams n beats with m_data_ready high; lastMask bit i marks beat i as last.
    task automatic sendBeats(input int n, input logic [31:0] firstData, input logic [31:0] lastMask);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, firstData + 32'(i));
            #1;
            checkOutput("beat_sready", s_data_ready, 1);
            tick();
            checkOutput("beat_valid", m_data_valid, 1);
            checkOutput("beat_data", m_data, 64'(firstData + 32'(i)));
            checkOutput("beat_last", m_data_last, 64'(lastMask[i]));
        end
        applyStimulus(1'b0, 32'h0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_addr_valid"}, m_addr_valid, 0);
        checkOutput({tag, "_data_valid"}, m_data_valid, 0);
        checkOutput({tag, "_data_last"}, m_data_last, 0);
        checkOutput({tag, "_sdata_ready"}, s_data_ready, 0);
        checkOutput({tag, "_saddr_ready"}, s_addr_ready, 0);
        checkOutput({tag, "_m_addr"}, m_addr, 0);
        checkOutput({tag, "_m_length"}, m_length, 0);
        checkOutput({tag, "_m_data"}, m_data, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        s_addr       = '0;
        s_length     = '0;
        s_addr_valid = 1'b0;
        s_data       = '0;
        s_data_valid = 1'b0;
        m_addr_ready = 1'b1;
        m_data_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_saddr_ready", s_addr_ready, 1);

        // Multi-chunk split: 0x100, 10 beats -> 4+4+2.
        $display("[TB] multi-chunk split");
        applyRequest(32'h100, 8'd9);
        checkOutput("mc_saddr_ready", s_addr_ready, 0);
        checkSubBurst("mc0", 32'h100, 8'd3);
        tick();
        checkSubBurst("mc1", 32'h104, 8'd3);
        tick();
        checkSubBurst("mc2", 32'h108, 8'd1);
        tick();
        checkOutput("mc_done_valid", m_addr_valid, 0);
        checkOutput("mc_done_ready", s_addr_ready, 1);
        sendBeats(10, 32'h0, 32'h288);
        tick();
        checkOutput("mc_drain_valid", m_data_valid, 0);
        checkOutput("mc_drain_sready", s_data_ready, 0);

        // Single beat request.
        $display("[TB] single beat");
        applyRequest(32'h40, 8'd0);
        checkSubBurst("sb", 32'h40, 8'd0);
        checkOutput("sb_saddr_ready_busy", s_addr_ready, 0);
        tick();
        checkOutput("sb_saddr_ready_back", s_addr_ready, 1);
        sendBeats(1, 32'hAB, 32'h1);
        tick();

        // Address stall: first sub-burst held while m_addr_ready is low.
        $display("[TB] address stall");
        m_addr_ready = 1'b0;
        applyRequest(32'h0, 8'd7);
        for (int i = 0; i < 5; i++) begin
            checkSubBurst("stall", 32'h0, 8'd3);
            checkOutput("stall_saddr_ready", s_addr_ready, 0);
            tick();
        end
        m_addr_ready = 1'b1;
        #1;
        checkSubBurst("stall_release", 32'h0, 8'd3);
        tick();
        checkSubBurst("stall_next", 32'h4, 8'd3);
        tick();
        checkOutput("stall_done_ready", s_addr_ready, 1);
        sendBeats(8, 32'h20, 32'h88);
        tick();

        // FIFO backpressure: 5 sub-bursts, FIFO holds 4.
        $display("[TB] fifo backpressure");
        applyRequest(32'h300, 8'd19);
        for (int k = 0; k < 4; k++) begin
            checkSubBurst("bp_issue", 32'h300 + 32'(4 * k), 8'd3);
            tick();
        end
        checkOutput("bp_full_valid", m_addr_valid, 0);
        checkOutput("bp_full_saddr_ready", s_addr_ready, 0);
        tick();
        tick();
        checkOutput("bp_full_hold", m_addr_valid, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h50 + 32'(i));
            tick();
            checkOutput("bp_after_beat_valid", m_addr_valid, (i == 3) ? 64'd1 : 64'd0);
        end
        applyStimulus(1'b0, 32'h0);
        checkOutput("bp_first_last", m_data_last, 1);
        checkSubBurst("bp_fifth", 32'h310, 8'd3);
        tick();
        checkOutput("bp_done_valid", m_addr_valid, 0);
        checkOutput("bp_done_ready", s_addr_ready, 1);
        sendBeats(16, 32'h60, 32'h8888);
        tick();

        // Data before address is stalled.
        $display("[TB] data before address");
        applyStimulus(1'b1, 32'hDEAD);
        #1;
        checkOutput("early_sdata_ready", s_data_ready, 0);
        tick();
        checkOutput("early_mdata_valid", m_data_valid, 0);
        applyStimulus(1'b0, 32'h0);

        // Reset in the middle of a 4-beat sub-burst.
        $display("[TB] reset mid-burst");
        applyRequest(32'h80, 8'd3);
        checkSubBurst("mid", 32'h80, 8'd3);
        tick();
        applyStimulus(1'b1, 32'hA0);
        tick();
        applyStimulus(1'b1, 32'hA1);
        tick();
        checkOutput("mid_beat1_data", m_data, 32'hA1);
        checkOutput("mid_beat1_last", m_data_last, 0);
        m_data_ready = 1'b0;
        applyStimulus(1'b0, 32'h0);
        tick();
        checkOutput("hold_data", m_data, 32'hA1);
        checkOutput("hold_valid", m_data_valid, 1);
        checkOutput("hold_last", m_data_last, 0);
        checkOutput("hold_sready", s_data_ready, 0);
        m_data_ready = 1'b1;
        applyStimulus(1'b1, 32'hA2);
        rst_n = 1'b0;
        tick();
        checkResetOutputs("midrst");
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0);
        tick();
        checkOutput("midrst_ready", s_addr_ready, 1);
        checkOutput("midrst_sready", s_data_ready, 0);
        applyRequest(32'h200, 8'd3);
        checkSubBurst("after_rst", 32'h200, 8'd3);
        tick();
        checkOutput("after_rst_done", s_addr_ready, 1);
        sendBeats(4, 32'h10, 32'h8);
        tick();

        // 4 KB boundary handling.
        $display("[TB] 4KB boundary");
        applyRequest(32'hFFE, 8'd3);
`ifdef BURST_WRITE_SPLITTER_4K_EN
        checkSubBurst("page0", 32'hFFE, 8'd1);
        tick();
        checkSubBurst("page1", 32'h1000, 8'd1);
        tick();
        checkOutput("page_done", s_addr_ready, 1);
        sendBeats(4, 32'h70, 32'hA);
`else
        checkSubBurst("page0", 32'hFFE, 8'd3);
        tick();
        checkOutput("page_done", s_addr_ready, 1);
        sendBeats(4, 32'h70, 32'h8);
`endif
        tick();
        checkOutput("final_idle_valid", m_data_valid, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
